// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I core; every datapath select/strobe is a registered Moore decode.
// Optional `define MC_TRAP_EN: unknown opcodes park in a sticky TRAP state (14) with Illegal=1 until rst.
module multicycle_controller #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         Op,
   input  logic [2:0]         Func3In,
   input  logic               Func7b5,
   output logic               IRWrite,
   output logic               PCUpdate,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         ResultSrc,
   output logic [2:0]         ImmSrc,
   output logic               Branch,
   output logic               Jump,
   output logic               JumpReg,
   output logic [2:0]         Func3,
   output logic               Done,
`ifdef MC_TRAP_EN
   output logic               Illegal,
`endif
   output logic [STATE_W-1:0] State
);

   typedef enum logic [STATE_W-1:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
      ALUWB, BRANCH, JAL, JALR, JALRPC, LUI
`ifdef MC_TRAP_EN
      , TRAP
`endif
   } state_t;

   typedef struct packed {
      logic       irwrite;
      logic       pcupdate;
      logic       adrsrc;
      logic       memwrite;
      logic       regwrite;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] resultsrc;
      logic [2:0] immsrc;
      logic       branch;
      logic       jump;
      logic       jumpreg;
      logic [2:0] func3;
      logic       done;
`ifdef MC_TRAP_EN
      logic       illegal;
`endif
   } ctrl_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   state_t state;
   ctrl_t  ctrl;

   // Funct7 bit 30 only matters to the ALU decoder, never to sequencing.
   logic unused_func7b5;
   assign unused_func7b5 = Func7b5;

   function automatic state_t next_state(input state_t s, input logic [6:0] op);
      state_t n;
      n = FETCH;
      case (s)
         FETCH:  n = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: n = MEMADR;
               OP_R:         n = EXECR;
               OP_I:         n = EXECI;
               OP_BR:        n = BRANCH;
               OP_JAL:       n = JAL;
               OP_JALR:      n = JALR;
               OP_LUI:       n = LUI;
`ifdef MC_TRAP_EN
               default:      n = TRAP;
`else
               default:      n = FETCH;
`endif
            endcase
         end
         MEMADR:  n = (op == OP_LW) ? MEMREAD : MEMWRITE;
         MEMREAD: n = MEMWB;
         EXECR, EXECI, JAL, JALRPC: n = ALUWB;
         JALR:    n = JALRPC;
`ifdef MC_TRAP_EN
         TRAP:    n = TRAP;
`endif
         default: n = FETCH;
      endcase
      return n;
   endfunction

   // Output bundle for a state; everything not named for that state stays 0.
   function automatic ctrl_t decode(input state_t s, input logic [6:0] op, input logic [2:0] f3);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:    begin c.irwrite = 1'b1; c.pcupdate = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
         DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; c.immsrc = IMM_B; end
         MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.immsrc = (op == OP_SW) ? IMM_S : IMM_I; end
         MEMREAD:  c.adrsrc = 1'b1;
         MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; c.done = 1'b1; end
         MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; c.done = 1'b1; end
         EXECR:    begin c.alusrca = 2'b10; c.aluop = 2'b10; end
         EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.immsrc = IMM_I; c.aluop = 2'b10; end
         ALUWB:    begin c.regwrite = 1'b1; c.done = 1'b1; end
         BRANCH:   begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; c.func3 = f3; c.done = 1'b1; end
         JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.immsrc = IMM_J; c.jump = 1'b1; end
         JALR:     begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.immsrc = IMM_I; end
         JALRPC:   begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.jumpreg = 1'b1; end
         LUI:      begin c.immsrc = IMM_U; c.resultsrc = 2'b11; c.regwrite = 1'b1; c.done = 1'b1; end
`ifdef MC_TRAP_EN
         TRAP:     c.illegal = 1'b1;
`endif
         default:  c = '0;
      endcase
      return c;
   endfunction

   // Outputs are registered from the next state so they line up with State in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         ctrl  <= decode(FETCH, 7'd0, 3'd0);
      end else begin
         state <= next_state(state, Op);
         ctrl  <= decode(next_state(state, Op), Op, Func3In);
      end
   end

   assign IRWrite   = ctrl.irwrite;
   assign PCUpdate  = ctrl.pcupdate;
   assign AdrSrc    = ctrl.adrsrc;
   assign MemWrite  = ctrl.memwrite;
   assign RegWrite  = ctrl.regwrite;
   assign ALUSrcA   = ctrl.alusrca;
   assign ALUSrcB   = ctrl.alusrcb;
   assign ALUOp     = ctrl.aluop;
   assign ResultSrc = ctrl.resultsrc;
   assign ImmSrc    = ctrl.immsrc;
   assign Branch    = ctrl.branch;
   assign Jump      = ctrl.jump;
   assign JumpReg   = ctrl.jumpreg;
   assign Func3     = ctrl.func3;
   assign Done      = ctrl.done;
`ifdef MC_TRAP_EN
   assign Illegal   = ctrl.illegal;
`endif
   assign State     = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multi-cycle RV32I core. It sequences fetch/decode/execute/memory/writeback and drives every datapath select and strobe. It drives the Branch, Jump and JumpReg levels plus the Func3 field consumed by the PC-select logic, the producer side of the branch/jump interface. Outputs are Moore, decoded from the state register only; Op/Func3/Func7b5 are sampled from the instruction register.

Parameters:
STATE_W, 4, state register width (states encoded 0..13)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
Op  input  7  instruction opcode from IR
Func3In  input  3  instruction funct3 from IR
Func7b5  input  1  instruction bit 30
IRWrite  output  1  load instruction register (and OldPC)
PCUpdate  output  1  unconditional PC write
AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write strobe
RegWrite  output  1  register file write strobe
ALUSrcA  output  2  00=PC, 01=OldPC, 10=RegA
ALUSrcB  output  2  00=RegB, 01=ImmExt, 10=constant 4
ALUOp  output  2  00=add, 01=subtract/compare, 10=decode from funct fields
ResultSrc  output  2  00=ALUOut, 01=MemData, 10=ALUResult, 11=ImmExt
ImmSrc  output  3  000=I, 001=S, 010=B, 011=J, 100=U
Branch  output  1  conditional PC write enable to PC-select logic
Jump  output  1  jal target select
JumpReg  output  1  jalr target select
Func3  output  3  Func3In forwarded, valid while Branch=1
Done  output  1  one-cycle pulse in last state of each instruction
State  output  STATE_W  current state (debug)

Behaviour:
- Reset: async to FETCH; State=0. All outputs take FETCH values: IRWrite=1, PCUpdate=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, all other strobes 0. Reset mid-instruction aborts it; no MemWrite/RegWrite while or after rst asserted.
- States and encoding: FETCH0 DECODE1 MEMADR2 MEMREAD3 MEMWB4 MEMWRITE5 EXECR6 EXECI7 ALUWB8 BRANCH9 JAL10 JALR11 JALRPC12 LUI13.
- FETCH: IR<=mem[PC], PC<=PC+4 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=B (OldPC+imm to ALUOut). Next by Op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; any other -> FETCH.
- MEMADR: A=10, B=01, ALUOp=00, ImmSrc=I for lw, S for sw -> MEMREAD (lw) / MEMWRITE (sw).
- MEMREAD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegWrite=1, Done -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, Done -> FETCH.
- EXECR: A=10, B=00, ALUOp=10 -> ALUWB. EXECI: A=10, B=01, ImmSrc=I, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Done -> FETCH.
- BRANCH: A=10, B=00, ALUOp=01, ResultSrc=00, Branch=1, Func3 valid, Done -> FETCH.
- JAL: ImmSrc=J, ResultSrc=00, Jump=1 (PC<=ALUOut), A=01, B=10, ALUOp=00 -> ALUWB.
- JALR: A=10, B=01, ImmSrc=I, ALUOp=00 -> JALRPC. JALRPC: ResultSrc=00, JumpReg=1, A=01, B=10 -> ALUWB.
- LUI: ImmSrc=U, ResultSrc=11, RegWrite=1, Done -> FETCH.
- Cycle counts, FETCH to Done inclusive: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3. Unknown opcode returns to FETCH after 2 cycles with no Done.
- Branch, Jump, JumpReg mutually exclusive; each high exactly one cycle per instruction. PCUpdate high only in FETCH.
- Unused outputs in a state are 0.

Optional Feature:
MC_TRAP_EN: adds TRAP state 14 and output Illegal (1 bit). With it, an unknown opcode in DECODE -> TRAP. TRAP drives all strobes 0 and Illegal=1, holding until rst. Without it, no TRAP state and no Illegal port; unknown opcodes return to FETCH.

Test Plan:
- rst=1 mid-MEMWRITE, async -> State=0, MemWrite=0 same cycle; after release IRWrite=1, PCUpdate=1.
- Op=0000011 -> states 0,1,2,3,4; RegWrite=1, ResultSrc=01 only in state 4; Done once.
- Op=1100011, Func3In=3'h1 -> states 0,1,9; Branch=1, Func3=3'h1, ALUOp=01 in state 9; 3 cycles.
- Op=1100111 -> states 0,1,11,12,8; JumpReg=1 only in 12; RegWrite in 8.
- Op=0110111 -> states 0,1,13; ResultSrc=11, ImmSrc=100, RegWrite=1.
- Op=7'h7F -> default build: states 0,1,0 with no strobes; MC_TRAP_EN build: State=14, Illegal=1 held 10+ cycles until rst.
